genbuf_rx_dispatch: RTL and testbench
=====================================

// Module: genbuf_rx_dispatch
// PURPOSE
//  Buffer-side transmitter for the GenBuf receiver interface. It pops words from the
//  shared FIFO and delivers each one to one of two receivers over the BtoR_REQi/RtoB_ACKi
//  four-phase handshake, alternating receivers round-robin. It drives the signals that
//  the G7 (BtoR_REQ0/1) and G12 (EMPTY/DEQ) DBW monitors observe. Two receivers only.
// PARAMETERS
//  DATA_W   32  width of FIFO word and BtoR_DATA
//  TIMEOUT  16  max cycles REQ may wait for ACK (used only with GENBUF_ACK_TIMEOUT_EN), >=2
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  EMPTY       in   1       FIFO empty flag (FIFO is first-word-fall-through)
//  FIFO_DATA   in   DATA_W  FIFO head word, valid when EMPTY=0
//  DEQ         out  1       one-cycle pop strobe to FIFO
//  BtoR_REQ0   out  1       request to receiver 0
//  BtoR_REQ1   out  1       request to receiver 1
//  RtoB_ACK0   in   1       acknowledge from receiver 0
//  RtoB_ACK1   in   1       acknowledge from receiver 1
//  BtoR_DATA   out  DATA_W  word offered to receivers, stable while any REQ is high
//  ACK_TO_ERR  out  1       sticky ACK-timeout flag (tied 0 without the macro)
// BEHAVIOUR
//  - All outputs registered. Reset: DEQ=0, BtoR_REQ0/1=0, BtoR_DATA=0, ACK_TO_ERR=0,
//    state=IDLE, ptr=0 (receiver 0 served first). Reset mid-handshake aborts, no DEQ.
//  - FSM: IDLE -> REQ -> REL -> IDLE. sel = ptr captured on leaving IDLE.
//  - IDLE: if EMPTY=0 and RtoB_ACK[ptr]=0: next cycle BtoR_REQ[ptr]=1, BtoR_DATA<=FIFO_DATA,
//    go REQ. Otherwise stay; no outputs asserted.
//  - REQ: hold REQ[sel] and BtoR_DATA. On RtoB_ACK[sel]=1 at cycle t: at t+1 REQ[sel]=0,
//    DEQ=1 for exactly one cycle, go REL. ACK of the non-selected receiver ignored.
//  - REL: wait RtoB_ACK[sel]=0; on that cycle ptr<=~sel, go IDLE. Next REQ earliest 1 cycle
//    after IDLE entry, i.e. >=2 cycles after ACK falls.
//  - Invariants: never BtoR_REQ0 & BtoR_REQ1; DEQ only when EMPTY=0; exactly one DEQ per
//    completed handshake; REQ never drops before ACK (except timeout/reset).
//  - Latency: EMPTY fall at t -> REQ at t+1; ACK rise at t -> REQ fall + DEQ at t+1.
//  - EMPTY rising while in REQ/REL impossible (sole consumer); ignored if seen.
//  - Simultaneous ACK0 and ACK1: only ACK[sel] acts.
// CONFIGURATION
//  GENBUF_ACK_TIMEOUT_EN defined: counter (clog2(TIMEOUT) bits) clears on REQ entry,
//   increments each REQ cycle without ACK[sel]; on reaching TIMEOUT-1 without ACK: next
//   cycle REQ[sel]=0, no DEQ, ACK_TO_ERR<=1 (sticky until rst), ptr<=~sel, go IDLE. Word
//   stays in FIFO and is offered to the other receiver. ACK on the terminal cycle wins.
//  Undefined: no counter; REQ waits indefinitely; ACK_TO_ERR constant 0.
// TESTING
//  1. rst 3 cycles, EMPTY=1 -> all outputs 0, no REQ for 20 cycles.
//  2. EMPTY=0, FIFO_DATA=32'hA5A5_0001; ACK0 2 cycles after REQ0 -> REQ0 1 cycle after
//     EMPTY falls, BtoR_DATA=A5A5_0001, DEQ single pulse with REQ0 fall.
//  3. 4 words queued, receivers ACK after 1 cycle -> REQ order 0,1,0,1; 4 DEQ pulses;
//     never REQ0&REQ1.
//  4. ACK0 held high 5 cycles after REQ0 drops -> no REQ1 until 2 cycles after ACK0 falls.
//  5. rst asserted during REQ state -> REQ0=0 next cycle, no DEQ, ptr back to 0.
//  6. (macro on, TIMEOUT=16) receiver 0 never ACKs -> REQ0 drops after 16 cycles,
//     ACK_TO_ERR=1, no DEQ, same word offered on REQ1; macro off -> REQ0 held 100 cycles.

Source files
------------

// File: rtl/genbuf_rx_dispatch.sv
// GenBuf buffer-side dispatcher: pops FIFO words and hands each to one of two receivers
// over a four-phase REQ/ACK handshake, round-robin. Optional macro GENBUF_ACK_TIMEOUT_EN.
module genbuf_rx_dispatch #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EMPTY,
  input  logic [DATA_W-1:0] FIFO_DATA,
  output logic              DEQ,
  output logic              BtoR_REQ0,
  output logic              BtoR_REQ1,
  input  logic              RtoB_ACK0,
  input  logic              RtoB_ACK1,
  output logic [DATA_W-1:0] BtoR_DATA,
  output logic              ACK_TO_ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              ptr, ptr_nxt;
  logic              sel, sel_nxt;
  logic [1:0]        req_q, req_nxt;
  logic              deq_q, deq_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              err_q, err_nxt;
  logic [1:0]        ack;
  logic              ack_ptr;
  logic              ack_sel;
  logic              expired;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("genbuf_rx_dispatch: TIMEOUT must be at least 2");
  end

  assign ack     = {RtoB_ACK1, RtoB_ACK0};
  assign ack_ptr = ack[ptr];
  assign ack_sel = ack[sel];

`ifdef GENBUF_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;

  // Counts REQ cycles spent waiting; idling clears it so every offer starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != REQ) begin
      wait_cnt <= '0;
    end else if (!ack_sel) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      sel    <= 1'b0;
      req_q  <= 2'b00;
      deq_q  <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      sel    <= sel_nxt;
      req_q  <= req_nxt;
      deq_q  <= deq_nxt;
      data_q <= data_nxt;
      err_q  <= err_nxt;
    end
  end

  // An ACK on the timeout's terminal cycle still completes the handshake normally.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    req_nxt   = req_q;
    deq_nxt   = 1'b0;
    data_nxt  = data_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        req_nxt = 2'b00;
        if (!EMPTY && !ack_ptr) begin
          sel_nxt      = ptr;
          req_nxt[ptr] = 1'b1;
          data_nxt     = FIFO_DATA;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        if (ack_sel) begin
          req_nxt   = 2'b00;
          deq_nxt   = 1'b1;
          state_nxt = REL;
        end else if (expired) begin
          req_nxt   = 2'b00;
          err_nxt   = 1'b1;
          ptr_nxt   = ~sel;
          state_nxt = IDLE;
        end
      end
      REL: begin
        if (!ack_sel) begin
          ptr_nxt   = ~sel;
          state_nxt = IDLE;
        end
      end
      default: begin
        req_nxt   = 2'b00;
        state_nxt = IDLE;
      end
    endcase
  end

  assign DEQ        = deq_q;
  assign BtoR_REQ0  = req_q[0];
  assign BtoR_REQ1  = req_q[1];
  assign BtoR_DATA  = data_q;
  assign ACK_TO_ERR = err_q;

endmodule

// File: tb/tb_genbuf_rx_dispatch.sv
// Self-checking bench for genbuf_rx_dispatch: bench-side FIFO and receivers, a handshake-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_genbuf_rx_dispatch;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              EMPTY;
  logic [DATA_W-1:0] FIFO_DATA;
  logic              DEQ;
  logic              BtoR_REQ0;
  logic              BtoR_REQ1;
  logic              RtoB_ACK0;
  logic              RtoB_ACK1;
  logic [DATA_W-1:0] BtoR_DATA;
  logic              ACK_TO_ERR;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  genbuf_rx_dispatch #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .EMPTY      (EMPTY),
    .FIFO_DATA  (FIFO_DATA),
    .DEQ        (DEQ),
    .BtoR_REQ0  (BtoR_REQ0),
    .BtoR_REQ1  (BtoR_REQ1),
    .RtoB_ACK0  (RtoB_ACK0),
    .RtoB_ACK1  (RtoB_ACK1),
    .BtoR_DATA  (BtoR_DATA),
    .ACK_TO_ERR (ACK_TO_ERR)
  );

  function automatic void check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endfunction

  // First-word-fall-through FIFO; a DEQ seen at an edge pops the head at that edge.
  logic [31:0] fifo_q[$];
  logic        deq_seen;

  function automatic void refresh_fifo();
    EMPTY     = (fifo_q.size() == 0);
    FIFO_DATA = EMPTY ? 32'h0 : fifo_q[0];
  endfunction

  always @(posedge clk) begin
    deq_seen = DEQ;
    #1;
    if (deq_seen === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh_fifo();
  end

  // Receivers: raise ACK ack_delay edges after seeing REQ (-1 never), drop it ack_hold edges after REQ falls.
  logic rx_ack [2];
  logic rx_req [2];
  int   rx_cnt [2];
  int   ack_delay [2];
  int   ack_hold [2];

  assign RtoB_ACK0 = rx_ack[0];
  assign RtoB_ACK1 = rx_ack[1];

  always @(posedge clk) begin
    rx_req[0] = BtoR_REQ0;
    rx_req[1] = BtoR_REQ1;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst === 1'b1) begin
        rx_ack[i] = 1'b0;
        rx_cnt[i] = 0;
      end else if (rx_ack[i] == 1'b0) begin
        if (rx_req[i] === 1'b1) begin
          rx_cnt[i]++;
          if (ack_delay[i] >= 0 && rx_cnt[i] >= ack_delay[i]) begin
            rx_ack[i] = 1'b1;
            rx_cnt[i] = 0;
          end
        end else begin
          rx_cnt[i] = 0;
        end
      end else if (rx_req[i] !== 1'b1) begin
        if (rx_cnt[i] >= ack_hold[i]) begin
          rx_ack[i] = 1'b0;
          rx_cnt[i] = 0;
        end else begin
          rx_cnt[i]++;
        end
      end
    end
  end

  // Reference model: tracks which receiver holds the offer and whether the word is delivered.
  logic        m_valid = 1'b0;
  logic        exp_req [2];
  logic        exp_deq;
  logic        exp_err;
  logic [31:0] exp_data;
  logic        m_ack [2];
  int          m_rx;
  bit          m_delivered;
  int          m_turn;
  int          m_age;

  always @(posedge clk) begin
    m_ack[0] = RtoB_ACK0;
    m_ack[1] = RtoB_ACK1;
    if (rst === 1'b1) begin
      m_valid     = 1'b1;
      exp_req[0]  = 1'b0;
      exp_req[1]  = 1'b0;
      exp_deq     = 1'b0;
      exp_err     = 1'b0;
      exp_data    = 32'h0;
      m_rx        = -1;
      m_delivered = 1'b0;
      m_turn      = 0;
      m_age       = 0;
    end else if (m_valid) begin
      exp_deq = 1'b0;
      if (m_rx < 0) begin
        if (!EMPTY && !m_ack[m_turn]) begin
          m_rx          = m_turn;
          m_age         = 0;
          exp_req[m_rx] = 1'b1;
          exp_data      = FIFO_DATA;
        end
      end else if (!m_delivered) begin
        m_age++;
        if (m_ack[m_rx]) begin
          exp_req[m_rx] = 1'b0;
          exp_deq       = 1'b1;
          m_delivered   = 1'b1;
        end
`ifdef GENBUF_ACK_TIMEOUT_EN
        else if (m_age == TIMEOUT) begin
          exp_req[m_rx] = 1'b0;
          exp_err       = 1'b1;
          m_turn        = 1 - m_rx;
          m_rx          = -1;
        end
`endif
      end else if (!m_ack[m_rx]) begin
        m_turn      = 1 - m_rx;
        m_rx        = -1;
        m_delivered = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_output("req0", BtoR_REQ0, exp_req[0]);
      check_output("req1", BtoR_REQ1, exp_req[1]);
      check_output("deq", DEQ, exp_deq);
      check_output("data", BtoR_DATA, exp_data);
      check_output("ack_to_err", ACK_TO_ERR, exp_err);
      check_output("no_dual_req", BtoR_REQ0 & BtoR_REQ1, 1'b0);
    end
  end

  // Observation log for directed expectations.
  logic        prev_req0 = 1'b0;
  logic        prev_req1 = 1'b0;
  logic        prev_ack0 = 1'b0;
  int          deq_count = 0;
  int          req_order[$];
  logic [31:0] req_words[$];
  int          last_ack0_fall = -1000;
  int          last_req1_rise = -1000;

  always @(negedge clk) begin
    if (BtoR_REQ0 === 1'b1 && prev_req0 !== 1'b1) begin
      req_order.push_back(0);
      req_words.push_back(BtoR_DATA);
    end
    if (BtoR_REQ1 === 1'b1 && prev_req1 !== 1'b1) begin
      req_order.push_back(1);
      req_words.push_back(BtoR_DATA);
      last_req1_rise = cyc;
    end
    if (RtoB_ACK0 === 1'b0 && prev_ack0 === 1'b1) last_ack0_fall = cyc;
    if (DEQ === 1'b1) deq_count++;
    prev_req0 = BtoR_REQ0;
    prev_req1 = BtoR_REQ1;
    prev_ack0 = RtoB_ACK0;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg_after(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_log();
    req_order.delete();
    req_words.delete();
    deq_count      = 0;
    last_ack0_fall = -1000;
    last_req1_rise = -1000;
  endtask

  task automatic do_reset(input int n);
    step();
    rst = 1'b1;
    fifo_q.delete();
    refresh_fifo();
    repeat (n) step();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic apply_stimulus(input logic [31:0] word);
    step();
    fifo_q.push_back(word);
    refresh_fifo();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rx_ack[i]    = 1'b0;
      rx_cnt[i]    = 0;
      ack_delay[i] = 1;
      ack_hold[i]  = 0;
    end
    refresh_fifo();

    // Reset state and quiet idle with an empty FIFO.
    do_reset(3);
    @(negedge clk);
    check_output("rst_req0", BtoR_REQ0, 1'b0);
    check_output("rst_req1", BtoR_REQ1, 1'b0);
    check_output("rst_deq", DEQ, 1'b0);
    check_output("rst_data", BtoR_DATA, 32'h0);
    check_output("rst_err", ACK_TO_ERR, 1'b0);
    repeat (20) step();
    check_output("idle_no_req", req_order.size(), 0);
    check_output("idle_no_deq", deq_count, 0);

    // Single word, receiver 0 acknowledges two cycles after REQ0.
    ack_delay[0] = 2;
    apply_stimulus(32'hA5A5_0001);
    at_neg_after(1);
    check_output("t2_req0_up", BtoR_REQ0, 1'b1);
    check_output("t2_data", BtoR_DATA, 32'hA5A5_0001);
    at_neg_after(3);
    check_output("t2_req0_down", BtoR_REQ0, 1'b0);
    check_output("t2_deq_pulse", DEQ, 1'b1);
    at_neg_after(1);
    check_output("t2_deq_single", DEQ, 1'b0);
    repeat (10) step();
    check_output("t2_deq_count", deq_count, 1);

    // Four queued words alternate receivers starting from receiver 0.
    do_reset(2);
    ack_delay[0] = 1;
    ack_delay[1] = 1;
    for (int k = 0; k < 4; k++) apply_stimulus(32'h3333_0000 + k);
    repeat (40) step();
    check_output("t3_req_count", req_order.size(), 4);
    for (int k = 0; k < 4 && k < req_order.size(); k++) begin
      check_output("t3_req_order", req_order[k], k % 2);
      check_output("t3_req_word", req_words[k], 32'h3333_0000 + k);
    end
    check_output("t3_deq_count", deq_count, 4);
    check_output("t3_fifo_drained", fifo_q.size(), 0);

    // Receiver 0 holds ACK after REQ0 drops; REQ1 must wait two cycles past the ACK fall.
    do_reset(2);
    ack_hold[0] = 5;
    apply_stimulus(32'h4444_0001);
    apply_stimulus(32'h4444_0002);
    repeat (40) step();
    ack_hold[0] = 0;
    check_output("t4_req_count", req_order.size(), 2);
    check_output("t4_req1_gap", last_req1_rise - last_ack0_fall, 2);
    check_output("t4_deq_count", deq_count, 2);

    // Reset mid-offer aborts without DEQ and restarts with receiver 0.
    do_reset(2);
    ack_delay[0] = -1;
    apply_stimulus(32'h5555_0005);
    at_neg_after(1);
    check_output("t5_req0_up", BtoR_REQ0, 1'b1);
    step();
    rst = 1'b1;
    at_neg_after(1);
    check_output("t5_req0_abort", BtoR_REQ0, 1'b0);
    check_output("t5_no_deq", DEQ, 1'b0);
    step();
    rst = 1'b0;
    repeat (5) step();
    check_output("t5_req_count", req_order.size(), 2);
    if (req_order.size() == 2) check_output("t5_restart_rx0", req_order[1], 0);
    check_output("t5_deq_count", deq_count, 0);

    // Receiver 0 never acknowledges.
    do_reset(2);
    apply_stimulus(32'hC0DE_0006);
    at_neg_after(1);
    check_output("t6_req0_up", BtoR_REQ0, 1'b1);
`ifdef GENBUF_ACK_TIMEOUT_EN
    at_neg_after(15);
    check_output("t6_req0_held", BtoR_REQ0, 1'b1);
    at_neg_after(1);
    check_output("t6_req0_timeout", BtoR_REQ0, 1'b0);
    check_output("t6_err_set", ACK_TO_ERR, 1'b1);
    check_output("t6_no_deq", DEQ, 1'b0);
    repeat (10) step();
    check_output("t6_req_count", req_order.size(), 2);
    if (req_order.size() == 2) begin
      check_output("t6_retry_rx1", req_order[1], 1);
      check_output("t6_retry_word", req_words[1], 32'hC0DE_0006);
    end
    check_output("t6_deq_count", deq_count, 1);
    check_output("t6_err_sticky", ACK_TO_ERR, 1'b1);
`else
    at_neg_after(99);
    check_output("t6_req0_held", BtoR_REQ0, 1'b1);
    check_output("t6_no_deq", deq_count, 0);
    check_output("t6_err_zero", ACK_TO_ERR, 1'b0);
    check_output("t6_req_count", req_order.size(), 1);
`endif
    ack_delay[0] = 1;
    do_reset(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
